nes_pad_reader: RTL and testbench



---
 rtl/nes_pad_reader.sv | 179 +++++++++++++++++
 tb/tb_nes_pad_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls NUM_PADS NES/SNES controllers in parallel.
// Generates pad_latch and pad_clk, shifts the active-low serial data from
// every pad at once, and publishes an active-high button word per pad
// together with a one-cycle valid strobe. Polls continuously while enabled.
//
// Optional build macro: NES_PAD_EDGE_EN adds the 'pressed' output, which
// holds the buttons that went from released to pressed in the last poll.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   enable     1 = keep polling
//   pad_data   serial data per pad (active-low, asynchronous)
//   pad_latch  latch to all pads, active-high
//   pad_clk    shift clock to all pads, idles low
//   buttons    pad p bit i at index p*NUM_BITS+i, 1 = pressed
//   pressed    (NES_PAD_EDGE_EN only) newly pressed buttons
//   valid      one-cycle pulse while buttons holds a fresh word
//   busy       high in every state except IDLE
module nes_pad_reader #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8,
  parameter int CLK_DIV  = 150,
  parameter int POLL_GAP = 100
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
`ifdef NES_PAD_EDGE_EN
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
`endif
  output logic                         valid,
  output logic                         busy
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int UW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);
  localparam logic [UW-1:0] LATCH_LAST = UW'(1);
  localparam logic [UW-1:0] GAP_LAST   = UW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_BIT_LO = 3'd2;
  localparam logic [2:0] S_BIT_HI = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]          state;
  logic [TW-1:0]       tick;
  logic [BW-1:0]       bit_cnt;
  logic [UW-1:0]       unit_cnt;   // counts whole ticks in LATCH and GAP
  logic [NUM_PADS-1:0] sync_q1;
  logic [NUM_PADS-1:0] sync_q2;
  logic [NUM_BITS-1:0] shadow [NUM_PADS];
  logic [NUM_PADS*NUM_BITS-1:0] shadow_flat;
  logic                tick_end;
  logic [IW-1:0]       bit_idx;

  assign tick_end = (tick == TICK_LAST);
  assign bit_idx  = bit_cnt[IW-1:0];

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_flat
    assign shadow_flat[p*NUM_BITS +: NUM_BITS] = shadow[p];
  end

  assign pad_latch = (state == S_LATCH);
  assign pad_clk   = (state == S_BIT_HI);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= pad_data;
      sync_q2 <= sync_q1;
    end
  end

  // buttons/valid are loaded on the edge that enters DONE so that the new
  // word is already visible during the single DONE cycle where valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      unit_cnt <= '0;
      buttons  <= '0;
      valid    <= 1'b0;
`ifdef NES_PAD_EDGE_EN
      pressed  <= '0;
`endif
      for (int unsigned p = 0; p < NUM_PADS; p++) shadow[p] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_LATCH;
            tick     <= '0;
            unit_cnt <= '0;
          end
        end
        S_LATCH: begin
          if (tick_end) begin
            tick <= '0;
            if (unit_cnt == LATCH_LAST) begin
              unit_cnt <= '0;
              bit_cnt  <= '0;
              state    <= S_BIT_LO;
            end else begin
              unit_cnt <= unit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_BIT_LO: begin
          if (tick_end) begin
            for (int unsigned p = 0; p < NUM_PADS; p++)
              shadow[p][bit_idx] <= ~sync_q2[p];
            tick  <= '0;
            state <= S_BIT_HI;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (tick_end) begin
            tick    <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state   <= S_DONE;
              buttons <= shadow_flat;
              valid   <= 1'b1;
`ifdef NES_PAD_EDGE_EN
              pressed <= shadow_flat & ~buttons;
`endif
            end else begin
              state <= S_BIT_LO;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_DONE: begin
          tick     <= '0;
          unit_cnt <= '0;
          if (POLL_GAP > 0) state <= S_GAP;
          else              state <= enable ? S_LATCH : S_IDLE;
        end
        S_GAP: begin
          if (tick_end) begin
            tick <= '0;
            if (unit_cnt == GAP_LAST) begin
              unit_cnt <= '0;
              state    <= enable ? S_LATCH : S_IDLE;
            end else begin
              unit_cnt <= unit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: an 8-bit and a 16-bit instance share
// clock, reset and enable; each is fed by a behavioural pad shift register.
// Expected button words are queued when the pad pattern is set and popped
// when the DUT raises valid.
module tb_nes_pad_reader;

  localparam int CLK_DIV  = 4;
  localparam int POLL_GAP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [1:0]  pad_data, pad_data16;
  logic        pad_latch, pad_clk, valid, busy;
  logic        latch16, pclk16, valid16, busy16;
  logic [15:0] buttons;
  logic [31:0] buttons16;
`ifdef NES_PAD_EDGE_EN
  logic [15:0] pressed;
  logic [31:0] pressed16;
  logic [15:0] last_exp = '0;
`endif

  nes_pad_reader #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(CLK_DIV), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
`ifdef NES_PAD_EDGE_EN
    .pressed(pressed),
`endif
    .valid(valid), .busy(busy));

  nes_pad_reader #(.NUM_PADS(2), .NUM_BITS(16), .CLK_DIV(CLK_DIV), .POLL_GAP(POLL_GAP)) dut16 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pad_data(pad_data16),
    .pad_latch(latch16), .pad_clk(pclk16), .buttons(buttons16),
`ifdef NES_PAD_EDGE_EN
    .pressed(pressed16),
`endif
    .valid(valid16), .busy(busy16));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural pads: latch reloads, each pad_clk rise advances one bit.
  logic [15:0] press   = '0;
  logic [31:0] press16 = '0;
  int   idx = 0, idx16 = 0;
  logic pq = 1'b0, pq16 = 1'b0;

  always @(negedge clk) begin
    if (pad_latch) idx <= 0;
    else if (pad_clk && !pq) idx <= idx + 1;
    pq <= pad_clk;
    if (latch16) idx16 <= 0;
    else if (pclk16 && !pq16) idx16 <= idx16 + 1;
    pq16 <= pclk16;
  end

  always_comb begin
    pad_data   = '1;
    pad_data16 = '1;
    if (idx < 8) begin
      pad_data[0] = ~press[{1'b0, idx[2:0]}];
      pad_data[1] = ~press[{1'b1, idx[2:0]}];
    end
    if (idx16 < 16) begin
      pad_data16[0] = ~press16[{1'b0, idx16[3:0]}];
      pad_data16[1] = ~press16[{1'b1, idx16[3:0]}];
    end
  end

  logic sel = 1'b0;
  logic m_latch, m_pclk, m_valid, m_busy;
  logic [31:0] m_btn;
  assign m_latch = sel ? latch16 : pad_latch;
  assign m_pclk  = sel ? pclk16  : pad_clk;
  assign m_valid = sel ? valid16 : valid;
  assign m_busy  = sel ? busy16  : busy;
  assign m_btn   = sel ? buttons16 : {16'h0000, buttons};

  logic [31:0] sb[$];
  logic [31:0] sb16[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_latch(input string tag, output int t);
    logic prev;
    bit   found;
    prev  = m_latch;
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_latch && !prev) begin
        found = 1'b1;
        t     = cyc;
        break;
      end
      prev = m_latch;
    end
    check({tag, "_latch_seen"}, 32'(found), 32'd1);
  endtask

  // Called at the first negedge with latch high; follows the poll to valid.
  task automatic run_poll(input string tag, input int t0, input int nb);
    int   lat_n, hi_n, pulses, vrel;
    logic prev;
    bit   seen, busy_ok;
    logic [31:0] exp;
    lat_n = 0; hi_n = 0; pulses = 0; vrel = 0;
    prev = 1'b0; seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (m_latch) lat_n++;
      if (m_pclk) hi_n++;
      if (m_pclk && !prev) pulses++;
      prev = m_pclk;
      if (!m_busy) busy_ok = 1'b0;
      if (m_valid) begin
        seen = 1'b1;
        vrel = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latch_cycles"}, 32'(lat_n), 32'(2 * CLK_DIV));
      check({tag, "_pulses"}, 32'(pulses), 32'(nb));
      check({tag, "_clk_high_cycles"}, 32'(hi_n), 32'(nb * CLK_DIV));
      check({tag, "_valid_latency"}, 32'(vrel), 32'((2 + 2 * nb) * CLK_DIV));
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      if ((sel ? sb16.size() : sb.size()) == 0) begin
        check({tag, "_scoreboard_entry"}, 32'd0, 32'd1);
      end else begin
        exp = sel ? sb16.pop_front() : sb.pop_front();
        check({tag, "_buttons"}, m_btn, exp);
`ifdef NES_PAD_EDGE_EN
        if (!sel) begin
          check({tag, "_pressed"}, {16'h0000, pressed}, {16'h0000, exp[15:0] & ~last_exp});
          last_exp = exp[15:0];
        end
`endif
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(m_valid), 32'd0);
        check({tag, "_buttons_hold"}, m_btn, exp);
      end
    end
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, rises, vcnt, lat_hi;
    bit hit;

    // 1: reset state, idle pads, poll shape and period
    press   = 16'h0000;
    press16 = 32'h8000_0000;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_clk", 32'(pad_clk), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_buttons", {16'h0000, buttons}, 32'd0);
    sb.push_back(32'h0000);
    reset_n = 1'b1;
    wait_latch("p1", t0);
    run_poll("p1", t0, 8);

    // 2: pad0 bits 0 and 7, pad1 bit 1
    press = 16'h0281;
    sb.push_back(32'h0281);
    wait_latch("p2", t1);
    check("p2_period", 32'(t1 - t0), 32'((2 + 16 + POLL_GAP) * CLK_DIV + 1));
    run_poll("p2", t1, 8);

    // 3: drop enable in BIT_LO of bit 3
    press = 16'h5a3c;
    sb.push_back(32'h5a3c);
    wait_latch("p3", t2);
    rises = 0;
    hit   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_clk && !pq) rises++;
      if (rises == 3 && !pad_clk) begin
        hit = 1'b1;
        break;
      end
    end
    check("p3_bit3_reached", 32'(hit), 32'd1);
    enable = 1'b0;
    vcnt   = 0;
    lat_hi = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (pad_latch) lat_hi++;
      if (valid) begin
        vcnt++;
        if (vcnt == 1 && sb.size() > 0) check("p3_buttons", {16'h0000, buttons}, sb.pop_front());
      end
    end
    check("p3_valid_count", 32'(vcnt), 32'd1);
    check("p3_latch_idle", 32'(lat_hi), 32'd0);
    check("p3_busy_idle", 32'(busy), 32'd0);
`ifdef NES_PAD_EDGE_EN
    last_exp = 16'h5a3c;
`endif
    press = 16'h0281;
    sb.push_back(32'h0281);
    enable = 1'b1;
    @(negedge clk);
    check("p4_latch_next_cycle", 32'(pad_latch), 32'd1);
    t3 = cyc;
    run_poll("p4", t3, 8);

    // 4: asynchronous reset mid-poll while pad_clk is high
    press = 16'h00f0;
    wait_latch("p5abort", t4);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pad_clk) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_clk_high", 32'(hit), 32'd1);
    check("abort_buttons_before", {16'h0000, buttons}, 32'h0281);
    #2 reset_n = 1'b0;
    #1;
    check("abort_buttons", {16'h0000, buttons}, 32'd0);
    check("abort_latch", 32'(pad_latch), 32'd0);
    check("abort_clk", 32'(pad_clk), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
`ifdef NES_PAD_EDGE_EN
    last_exp = '0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(32'h00f0);
    wait_latch("p5", t5);
    run_poll("p5", t5, 8);

    // 5: pad0 bit0 held for three polls (edge detect when enabled)
    press = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(32'h0001);
      wait_latch("p6", t0);
      run_poll("p6", t0, 8);
    end

    // 6: 16-bit instance, pad1 bit 15 pressed
    sel = 1'b1;
    sb16.push_back(32'h8000_0000);
    wait_latch("n16", t6);
    run_poll("n16", t6, 16);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("sb16_drained", 32'(sb16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
